phased_op_bank: RTL and testbench
=================================

Name: phased_op_bank

Overview:
- Parametrised banked transform stage. Accepts a stream of words and keeps a rolling write pointer over a DEPTH-entry register bank.
- Each accepted word is transformed by an operation chosen from the current epoch count, written into the bank, and echoed out with its slot address.
- Sits between an upstream producer and a downstream consumer. Uses valid/ready handshakes on both sides and supports full-pipeline backpressure.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 4, bank entries; power of two, at least 2. AW = log2(DEPTH).
- CNT_W, 8, epoch counter width; CNT_W-2 must be greater than AW.
- MOD_K, 5, modulus for the MOD operation; at least 1.
- SHIFT, 2, right-shift amount for the SHR operation.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear_all  input  1  synchronous clear of bank, pointers and pipeline.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept; equals ~stall & ~clear_all.
- in_data  input  WIDTH  input word.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  value written to the bank.
- out_addr  output  AW  bank slot written.
- out_phase  output  2  phase used for this result: 0=P0, 1=P1, 2=P2, 3=P3.

Behaviour:
- Reset (reset=0, async): ptr=0, cnt=0, s1_valid=0, out_valid=0, out_data=0, out_addr=0, out_phase=0, all bank entries 0.
- stall = out_valid & ~out_ready. While stall is high, every register holds its value.
- Accept: in_valid & in_ready.
  - S1 captures temp<=in_data, s1_addr<=ptr, s1_cnt<=cnt; s1_valid<=1.
  - ptr<=ptr+1 (wraps mod DEPTH); cnt<=cnt+1 (wraps mod 2^CNT_W).
- No accept and no stall: s1_valid<=0.
- Phase decode from s1_cnt:
  - P0 if s1_cnt < DEPTH.
  - P1 if s1_cnt < 2^(CNT_W-1).
  - P2 if s1_cnt < 3*2^(CNT_W-2).
  - P3 otherwise.
- Operations:
  - P0, s1_addr==0 or s1_addr==DEPTH-1: temp % MOD_K.
  - P0, other slots: temp*temp, truncated to the low WIDTH bits.
  - P1: temp>>1.
  - P2: temp>>SHIFT.
  - P3: 0.
  - All arithmetic is unsigned. The multiply is computed at 2*WIDTH bits before truncation.
- S2, when s1_valid & ~stall:
  - bank[s1_addr]<=result.
  - out_data<=result (write-through: the new value, never the stale one).
  - out_addr<=s1_addr, out_phase<=phase, out_valid<=1.
- S2, when ~s1_valid & ~stall: out_valid<=0.
- Latency: exactly 2 clk edges from accept to out_valid, with no stalls. Sustained throughput is 1 word per cycle.
- Backpressure: in_ready drops in the same cycle that stall rises. S1 holds its content, so no word is lost or duplicated.
- cnt wrap: after 2^CNT_W accepts, cnt returns to 0 and P0 re-enters. Because DEPTH divides 2^CNT_W, ptr is also 0 at that point.
- clear_all=1, synchronous, overrides accept and stall:
  - Bank zeroed; ptr=0, cnt=0, s1_valid=0, out_valid=0.
  - out_data, out_addr and out_phase hold their values.
  - in_ready=0 during that cycle.
- Reset mid-operation: in-flight words are discarded. The first word after reset is P0, slot 0.

Optional Feature:
- Macro: PHASE_OP_SAT_EN.
- Defined: the P0 square saturates to all ones when the 2*WIDTH product exceeds 2^WIDTH-1.
- Undefined: the P0 square truncates to the low WIDTH bits.
- All other operations are identical in both builds.

Test Plan:
- Default parameters; release reset; accept 13, 7, 70000, 9 back-to-back with out_ready=1 -> out_data 3, 49, 605032704, 4. out_addr 0,1,2,3; out_phase 0; first out_valid 2 cycles after the first accept.
- Continue: 5th accept 100 -> out_data 50, out_addr 0, phase 1. Accept #129 (cnt=128) of 100 -> 25, phase 2. Accept #193 (cnt=192) of 100 -> 0, phase 3. Accept #257 of 13 -> 3, phase 0, addr 0.
- Hold out_ready=0 for 3 cycles with in_valid=1 streaming 1,2,3,... -> out_data held, in_ready=0 for those cycles; after release the outputs continue in order with no gap or duplicate.
- Assert clear_all after 10 accepts -> out_valid=0 next cycle. Next accept of 13 -> out_data 3, out_addr 0, phase 0.
- Drop reset low mid-stream with s1_valid=1 -> all outputs 0 immediately. After release, first accept 7 -> out_data 2.
- With PHASE_OP_SAT_EN defined: accepts 13, 70000 -> second out_data 0xFFFFFFFF. Without the macro -> 605032704.

Source files
------------

// File: rtl/phased_op_bank.sv
// -----------------------------------------------------------------------------
// phased_op_bank
//   Banked transform stage. Each accepted word is transformed by an operation
//   selected from the epoch count captured with it. The result is written into
//   a DEPTH-entry register bank at a rolling slot pointer and echoed downstream
//   together with that slot address and the phase that produced it.
//   Two pipeline stages:
//     S1: captures word, slot and epoch count.
//     S2: applies the operation, writes the bank and drives the outputs.
//   Both stages freeze while the consumer backpressures.
//
// Optional build macro: PHASE_OP_SAT_EN
//   When defined, the P0 square saturates to all ones on overflow.
//   When undefined, the P0 square keeps the low WIDTH bits.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   clear_all  in   synchronous clear of bank, pointers and pipeline
//   in_valid   in   input word valid
//   in_ready   out  stage can accept (not stalled, not clearing)
//   in_data    in   input word [WIDTH]
//   out_valid  out  result valid
//   out_ready  in   consumer accepts the result
//   out_data   out  value written to the bank [WIDTH]
//   out_addr   out  bank slot written [log2(DEPTH)]
//   out_phase  out  phase used: 0=P0, 1=P1, 2=P2, 3=P3
// -----------------------------------------------------------------------------
module phased_op_bank #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter int MOD_K = 5,
    parameter int SHIFT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_all,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH)-1:0] out_addr,
    output logic [1:0]               out_phase
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]    LAST_SLOT = AW'(DEPTH - 1);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] P0_LIMIT  = CNT_W'(DEPTH);
    localparam logic [WIDTH-1:0] MOD_VAL   = WIDTH'(MOD_K);

    typedef enum logic [1:0] {
        PH_P0 = 2'd0,
        PH_P1 = 2'd1,
        PH_P2 = 2'd2,
        PH_P3 = 2'd3
    } phase_e;

    logic [AW-1:0]    r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_temp;
    logic [AW-1:0]    r_s1_addr;
    logic [CNT_W-1:0] r_s1_cnt;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_bank [DEPTH];

    logic             w_stall;
    logic             w_accept;
    phase_e           w_phase;
    logic [WIDTH-1:0] w_square;
    logic [WIDTH-1:0] w_result;
    logic             w_bank_unused;

    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall & ~clear_all;
    assign w_accept = in_valid & in_ready;

    // Debug tap on the slot about to be overwritten; not driven out of the block.
    assign w_bank_unused = ^r_bank[r_s1_addr];

`ifdef PHASE_OP_SAT_EN
    logic [2*WIDTH-1:0] w_sq_full;
    assign w_sq_full = {{WIDTH{1'b0}}, r_temp} * {{WIDTH{1'b0}}, r_temp};
    assign w_square  = (|w_sq_full[2*WIDTH-1:WIDTH]) ? {WIDTH{1'b1}} : w_sq_full[WIDTH-1:0];
`else
    // The low half of the double-width product depends only on the low
    // halves of the operands, so a WIDTH-bit multiply gives the same bits.
    assign w_square = r_temp * r_temp;
`endif

    // Phase decode: small counts are P0, then the counter quarters select P1/P2/P3.
    always_comb begin
        w_phase = PH_P0;
        if (r_s1_cnt < P0_LIMIT) begin
            w_phase = PH_P0;
        end else begin
            case (r_s1_cnt[CNT_W-1:CNT_W-2])
                2'b00, 2'b01: w_phase = PH_P1;
                2'b10:        w_phase = PH_P2;
                2'b11:        w_phase = PH_P3;
                default:      w_phase = PH_P3;
            endcase
        end
    end

    // Operation select: edge slots of P0 use modulus, inner P0 slots square.
    always_comb begin
        w_result = {WIDTH{1'b0}};
        case (w_phase)
            PH_P0: begin
                if ((r_s1_addr == {AW{1'b0}}) || (r_s1_addr == LAST_SLOT)) begin
                    w_result = r_temp % MOD_VAL;
                end else begin
                    w_result = w_square;
                end
            end
            PH_P1:   w_result = r_temp >> 1'b1;
            PH_P2:   w_result = r_temp >> SHIFT;
            PH_P3:   w_result = {WIDTH{1'b0}};
            default: w_result = {WIDTH{1'b0}};
        endcase
    end

    // S1 capture plus the rolling slot pointer and epoch counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= {AW{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_temp     <= {WIDTH{1'b0}};
            r_s1_addr  <= {AW{1'b0}};
            r_s1_cnt   <= {CNT_W{1'b0}};
            r_s1_valid <= 1'b0;
        end else if (clear_all) begin
            r_ptr      <= {AW{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_temp     <= in_data;
            r_s1_addr  <= r_ptr;
            r_s1_cnt   <= r_cnt;
            r_s1_valid <= 1'b1;
            r_ptr      <= r_ptr + PTR_ONE;
            r_cnt      <= r_cnt + CNT_ONE;
        end else if (!w_stall) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2 output register; clear drops valid but keeps the last presented word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= {WIDTH{1'b0}};
            out_addr  <= {AW{1'b0}};
            out_phase <= 2'd0;
        end else if (clear_all) begin
            out_valid <= 1'b0;
        end else if (!w_stall) begin
            if (r_s1_valid) begin
                out_valid <= 1'b1;
                out_data  <= w_result;
                out_addr  <= r_s1_addr;
                out_phase <= w_phase;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Bank storage, written with the same value that leaves on out_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= {WIDTH{1'b0}};
            end
        end else if (clear_all) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= {WIDTH{1'b0}};
            end
        end else if (!w_stall && r_s1_valid) begin
            r_bank[r_s1_addr] <= w_result;
        end
    end

endmodule

// File: tb/tb_phased_op_bank.sv
// -----------------------------------------------------------------------------
// tb_phased_op_bank
//   Directed scoreboard bench for phased_op_bank at default parameters.
//   Stimulus pushes the hand-computed expected word; a monitor pops and
//   compares on every output transfer (out_valid & out_ready).
// -----------------------------------------------------------------------------
module tb_phased_op_bank;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        clear_all = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_data   = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_addr;
    logic [1:0]  out_phase;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  a;
        logic [1:0]  p;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   n_acc    = 0;

`ifdef PHASE_OP_SAT_EN
    localparam logic [31:0] SQ70000 = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] SQ70000 = 32'd605032704;
`endif

    phased_op_bank dut (
        .clk       (clk),
        .reset     (reset),
        .clear_all (clear_all),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_phase (out_phase)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_phase(input int c);
        int m;
        m = c % 256;
        if (m < 4)        return 2'd0;
        else if (m < 128) return 2'd1;
        else if (m < 192) return 2'd2;
        else              return 2'd3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Offer one word; once accepted, queue its expected result.
    task automatic send(input logic [31:0] d, input logic [31:0] ed);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", {63'd0, in_ready}, 64'd1);
        end else begin
            sb.push_back('{d: ed, a: 2'(n_acc % 4), p: exp_phase(n_acc)});
            n_acc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 50) begin
            @(posedge clk);
            i++;
        end
        #1;
        chk("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: compare every transferred output word in order.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=0x%0h expected=none", out_data);
            end else begin
                mon_e = sb.pop_front();
                chk("out_word{data,addr,phase}", {28'd0, out_data, out_addr, out_phase},
                    {28'd0, mon_e.d, mon_e.a, mon_e.p});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_data",  {32'd0, out_data},  64'd0);
        chk("reset_out_addr",  {62'd0, out_addr},  64'd0);
        chk("reset_out_phase", {62'd0, out_phase}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

        // P0 words, two-edge latency
        send(32'd13, 32'd3);
        chk("latency_edge1_valid", {63'd0, out_valid}, 64'd0);
        send(32'd7, 32'd49);
        chk("latency_edge2_valid", {63'd0, out_valid}, 64'd1);
        chk("latency_edge2_data", {32'd0, out_data}, 64'd3);
        send(32'd70000, SQ70000);
        send(32'd9, 32'd4);

        // P1 begins at the fifth accept
        send(32'd100, 32'd50);

        // Backpressure while streaming 1..8 in P1 (expected k>>1)
        fork
            begin
                for (int k = 1; k <= 8; k++) begin
                    send(32'(k), 32'(k / 2));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                    chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
                    if (sb.size() > 0) begin
                        chk("stall_hold_data", {32'd0, out_data}, {32'd0, sb[0].d});
                    end else begin
                        chk("stall_queue_nonempty", 64'(sb.size()), 64'd1);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        // Walk the epoch counter through P2, P3 and the wrap back to P0
        while (n_acc < 128) send(32'd0, 32'd0);
        send(32'd100, 32'd25);
        while (n_acc < 192) send(32'd0, 32'd0);
        send(32'd100, 32'd0);
        while (n_acc < 256) send(32'd0, 32'd0);
        send(32'd13, 32'd3);
        drain();

        // Synchronous clear after 10 back-to-back accepts
        for (int k = 0; k < 10; k++) send(32'd0, 32'd0);
        clear_all = 1'b1;
        @(negedge clk);
        chk("clear_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        clear_all = 1'b0;
        chk("clear_dropped_in_flight", 64'(sb.size()), 64'd1);
        sb.delete();
        n_acc = 0;
        chk("clear_out_valid", {63'd0, out_valid}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("clear_bank_zero", {32'd0, dut.r_bank[i]}, 64'd0);
        end
        send(32'd13, 32'd3);
        drain();

        // Asynchronous reset with a word in S1
        send(32'd7, 32'd49);
        send(32'd7, 32'd49);
        reset = 1'b0;
        #1;
        chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset_out_data",  {32'd0, out_data},  64'd0);
        chk("midreset_out_addr",  {62'd0, out_addr},  64'd0);
        chk("midreset_out_phase", {62'd0, out_phase}, 64'd0);
        chk("midreset_s1_valid",  {63'd0, dut.r_s1_valid}, 64'd0);
        sb.delete();
        n_acc = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(32'd7, 32'd2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
